// File: rtl/dff_pipe_elastic_pkg.sv
// Shared constants and helpers for the elastic DFF pipeline.
package dff_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Width needed to count 0..depth occupied stages.
   function automatic int cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_elastic_if.sv
// Valid/ready bus of the elastic pipeline: upstream D side, downstream Q side, occupancy.
interface dff_pipe_elastic_if
   import dff_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = cw(DEPTH);

   logic [WIDTH-1:0] D;
   logic             D_VALID;
   logic             D_READY;
   logic [WIDTH-1:0] Q;
   logic             Q_VALID;
   logic             Q_READY;
   logic [CW-1:0]    COUNT;

   modport master (
      output D, D_VALID, Q_READY,
      input  D_READY, Q, Q_VALID, COUNT
   );

   modport slave (
      input  D, D_VALID, Q_READY,
      output D_READY, Q, Q_VALID, COUNT
   );

endinterface

// File: rtl/dff_pipe_elastic_stage.sv
// One elastic stage: a data register plus a valid flag.
// The stage loads whenever it is empty or the next stage is taking its word.
module dff_pipe_stage #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             up_ready
);

   assign up_ready = !out_valid | dn_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= RESET_DATA;
      end else if (up_ready) begin
         out_valid <= in_valid;
         // A bubble moves forward but leaves the old data in place.
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/dff_pipe_elastic.sv
// DEPTH-stage elastic register pipeline with bubble collapsing and occupancy count.
// D_READY is combinational from Q_READY through the per-stage ready chain.
module dff_pipe_elastic
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter int               DEPTH      = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_DATA = '0,
   parameter int               CW         = cw(DEPTH)
) (
   input logic               CK,
   input logic               R,
   dff_pipe_elastic_if.slave bus
);

   logic [DEPTH-1:0][WIDTH-1:0] data;
   logic [DEPTH-1:0]            v;
   logic [CW-1:0]               count;
   logic                        d_ready;
   logic                        in_xfer;
   logic                        out_xfer;

   // Each stage owns its ready wire so the chain is a set of distinct nets.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] up_data;
      logic             up_valid;
      logic             dn_rdy;
      logic             up_rdy;

      if (i == 0) begin : g_head
         assign up_data  = bus.D;
         assign up_valid = bus.D_VALID;
      end else begin : g_body
         assign up_data  = data[i-1];
         assign up_valid = v[i-1];
      end

      if (i == DEPTH - 1) begin : g_tail
         assign dn_rdy = bus.Q_READY;
      end else begin : g_link
         assign dn_rdy = g_stage[i+1].up_rdy;
      end

      dff_pipe_stage #(
         .WIDTH      (WIDTH),
         .RESET_DATA (RESET_DATA)
      ) u_stage (
         .clk       (CK),
         .rst       (R),
         .in_data   (up_data),
         .in_valid  (up_valid),
         .dn_ready  (dn_rdy),
         .out_data  (data[i]),
         .out_valid (v[i]),
         .up_ready  (up_rdy)
      );
   end

   assign d_ready  = g_stage[0].up_rdy;
   assign in_xfer  = bus.D_VALID & d_ready;
   assign out_xfer = v[DEPTH-1] & bus.Q_READY;

   always_ff @(posedge CK) begin
      if (R) begin
         count <= '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.D_READY = d_ready;
   assign bus.Q       = data[DEPTH-1];
   assign bus.Q_VALID = v[DEPTH-1];
   assign bus.COUNT   = count;

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Directed bench for dff_pipe_elastic (WIDTH=8, DEPTH=4, RESET_DATA=8'hA5):
// a vector table of per-cycle inputs/expected outputs plus a full-throughput sequence.
module tb_dff_pipe_elastic;

   typedef struct {
      logic       r;
      logic [7:0] d;
      logic       dv;
      logic       qr;
      logic       erdy;
      logic [7:0] eq;
      logic       eqv;
      logic [2:0] ecnt;
   } vec_t;

   logic ck;
   logic r;
   int   n_cmp;
   int   n_err;
   vec_t tbl[$];

   dff_pipe_elastic_if #(.WIDTH(8), .DEPTH(4)) bus ();

   dff_pipe_elastic #(
      .WIDTH      (8),
      .DEPTH      (4),
      .RESET_DATA (8'hA5)
   ) dut (
      .CK  (ck),
      .R   (r),
      .bus (bus)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   function automatic vec_t mk(input logic r_i, input logic [7:0] d_i, input logic dv_i,
                               input logic qr_i, input logic erdy_i, input logic [7:0] eq_i,
                               input logic eqv_i, input logic [2:0] ecnt_i);
      vec_t t;
      t.r = r_i; t.d = d_i; t.dv = dv_i; t.qr = qr_i;
      t.erdy = erdy_i; t.eq = eq_i; t.eqv = eqv_i; t.ecnt = ecnt_i;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   // Drive one cycle: check D_READY before the edge, registered outputs after it.
   task automatic apply(input vec_t t, input int idx);
      r           = t.r;
      bus.D       = t.d;
      bus.D_VALID = t.dv;
      bus.Q_READY = t.qr;
      #1;
      chk("d_ready", idx, 32'(bus.D_READY), 32'(t.erdy));
      @(posedge ck);
      #1;
      chk("q",       idx, 32'(bus.Q),       32'(t.eq));
      chk("q_valid", idx, 32'(bus.Q_VALID), 32'(t.eqv));
      chk("count",   idx, 32'(bus.COUNT),   32'(t.ecnt));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // reset with a word offered: it must be dropped
      tbl.push_back(mk(1, 8'h11, 1, 1, 1, 8'hA5, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'hA5, 0, 0));
      // streaming 01..08, latency 4, then drain
      tbl.push_back(mk(0, 8'h01, 1, 1, 1, 8'hA5, 0, 1));
      tbl.push_back(mk(0, 8'h02, 1, 1, 1, 8'hA5, 0, 2));
      tbl.push_back(mk(0, 8'h03, 1, 1, 1, 8'hA5, 0, 3));
      tbl.push_back(mk(0, 8'h04, 1, 1, 1, 8'h01, 1, 4));
      tbl.push_back(mk(0, 8'h05, 1, 1, 1, 8'h02, 1, 4));
      tbl.push_back(mk(0, 8'h06, 1, 1, 1, 8'h03, 1, 4));
      tbl.push_back(mk(0, 8'h07, 1, 1, 1, 8'h04, 1, 4));
      tbl.push_back(mk(0, 8'h08, 1, 1, 1, 8'h05, 1, 4));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h06, 1, 3));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h07, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h08, 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h08, 0, 0));
      // backpressure: fill to 4, stall, release
      tbl.push_back(mk(0, 8'h10, 1, 0, 1, 8'h08, 0, 1));
      tbl.push_back(mk(0, 8'h11, 1, 0, 1, 8'h08, 0, 2));
      tbl.push_back(mk(0, 8'h12, 1, 0, 1, 8'h08, 0, 3));
      tbl.push_back(mk(0, 8'h13, 1, 0, 1, 8'h10, 1, 4));
      tbl.push_back(mk(0, 8'h14, 1, 0, 0, 8'h10, 1, 4));
      tbl.push_back(mk(0, 8'h14, 1, 0, 0, 8'h10, 1, 4));
      tbl.push_back(mk(0, 8'h14, 1, 1, 1, 8'h11, 1, 4));
      tbl.push_back(mk(0, 8'h15, 1, 1, 1, 8'h12, 1, 4));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h13, 1, 3));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h14, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h15, 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h15, 0, 0));
      // bubble collapse under stall, then back-to-back release
      tbl.push_back(mk(0, 8'h20, 1, 0, 1, 8'h15, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h15, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h15, 0, 1));
      tbl.push_back(mk(0, 8'h21, 1, 0, 1, 8'h20, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h20, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h20, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h21, 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h21, 0, 0));
      // reset with three words in flight, then fresh traffic
      tbl.push_back(mk(0, 8'h40, 1, 0, 1, 8'h21, 0, 1));
      tbl.push_back(mk(0, 8'h41, 1, 0, 1, 8'h21, 0, 2));
      tbl.push_back(mk(0, 8'h42, 1, 0, 1, 8'h21, 0, 3));
      tbl.push_back(mk(1, 8'h43, 1, 1, 1, 8'hA5, 0, 0));
      tbl.push_back(mk(0, 8'h50, 1, 1, 1, 8'hA5, 0, 1));
      tbl.push_back(mk(0, 8'h51, 1, 1, 1, 8'hA5, 0, 2));
      tbl.push_back(mk(0, 8'h52, 1, 1, 1, 8'hA5, 0, 3));
      tbl.push_back(mk(0, 8'h53, 1, 1, 1, 8'h50, 1, 4));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h51, 1, 3));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h52, 1, 2));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h53, 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h53, 0, 0));

      r           = 1'b1;
      bus.D       = 8'h00;
      bus.D_VALID = 1'b0;
      bus.Q_READY = 1'b0;
      repeat (3) @(posedge ck);
      #1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // full pipe with continuous in/out: 30..33 fill, then 20 words at full rate
      for (int k = 0; k < 4; k++)
         apply(mk(0, 8'(8'h30 + k), 1, 0, 1, (k == 3) ? 8'h30 : 8'h53, (k == 3), 3'(k + 1)), 100 + k);
      for (int k = 0; k < 20; k++)
         apply(mk(0, 8'(8'h34 + k), 1, 1, 1, 8'(8'h31 + k), 1, 3'd4), 200 + k);
      for (int j = 1; j <= 4; j++)
         apply(mk(0, 8'h00, 0, 1, 1, (j == 4) ? 8'h47 : 8'(8'h44 + j), (j != 4), 3'(4 - j)), 300 + j);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
